// File: rtl/instr_encoder_loader.sv
// Encodes RV32I field bundles (R, I-ALU, LOAD, STORE, BRANCH) and writes them sequentially
// into instruction memory; one bundle per cycle, write lands the cycle after acceptance.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [2:0]            in_class,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [12:0]           in_imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_illegal,
  output logic                  err_align,
  output logic                  err_overflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0]   ONE       = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, FIN, FULL} state_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] issued;
  logic                accept;
  logic                legal;
  logic [31:0]         enc;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_class)
      3'd0:    enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1:    enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      3'd2:    enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd3:    enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd4:    enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        // issued runs one ahead of count while a write is in flight
        in_ready = (issued < DEPTH);
        if (accept) begin
          if (in_last)                           state_nxt = DRAIN;
          else if (legal && issued == LAST_SLOT) state_nxt = FULL;
        end
      end
      DRAIN:   state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      FULL:    state_nxt = FULL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued       <= '0;
      count        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      err_illegal  <= 1'b0;
      err_align    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if (imem_we) count <= count + ONE;
      if (state == IDLE && start) begin
        issued       <= '0;
        count        <= '0;
        err_illegal  <= 1'b0;
        err_align    <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (accept) begin
        if (legal) begin
          imem_we    <= 1'b1;
          imem_addr  <= BASE + issued[ADDR_WIDTH-1:0];
          imem_wdata <= enc;
          issued     <= issued + ONE;
          if (in_class == 3'd4 && in_imm[0]) err_align <= 1'b1;
        end else begin
          err_illegal <= 1'b1;
        end
      end
      if (state_nxt == FULL) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader with a 4-word memory.
module tb_instr_encoder_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        last;
  } bundle_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, in_last;
  logic [2:0]    in_class, in_funct3;
  logic [6:0]    in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [12:0]   in_imm;
  logic          imem_we, busy, done, err_illegal, err_align, err_overflow;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] cyc = 0;
  wr_t wr_q[$];

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_class(in_class), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .count(count), .err_illegal(err_illegal), .err_align(err_align),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({cyc, imem_addr, imem_wdata});
    if (done) done_cnt++;
  end

  // Reference encoder: places each field at its bit offset arithmetically.
  function automatic logic [31:0] ref_enc(input bundle_t b);
    logic [31:0] imm;
    imm = 32'(b.imm);
    case (b.cls)
      3'd0: return (32'(b.f7) << 25) + (32'(b.rs2) << 20) + (32'(b.rs1) << 15)
                 + (32'(b.f3) << 12) + (32'(b.rd) << 7) + 32'd51;
      3'd1: return ((imm % 4096) << 20) + (32'(b.rs1) << 15) + (32'(b.f3) << 12)
                 + (32'(b.rd) << 7) + 32'd19;
      3'd2: return ((imm % 4096) << 20) + (32'(b.rs1) << 15) + (32'(b.f3) << 12)
                 + (32'(b.rd) << 7) + 32'd3;
      3'd3: return (((imm / 32) % 128) << 25) + (32'(b.rs2) << 20) + (32'(b.rs1) << 15)
                 + (32'(b.f3) << 12) + ((imm % 32) << 7) + 32'd35;
      default: return (((imm / 4096) % 2) << 31) + (((imm / 32) % 64) << 25)
                 + (32'(b.rs2) << 20) + (32'(b.rs1) << 15) + (32'(b.f3) << 12)
                 + (((imm / 2) % 16) << 8) + (((imm / 2048) % 2) << 7) + 32'd99;
    endcase
  endfunction

  function automatic bundle_t mk(input int cls, f3, f7, rd, rs1, rs2, imm, last);
    bundle_t b;
    b.cls = 3'(cls); b.f3 = 3'(f3); b.f7 = 7'(f7); b.rd = 5'(rd);
    b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = 13'(imm); b.last = 1'(last);
    return b;
  endfunction

  function automatic bundle_t rand_bundle(input int legal_only);
    bundle_t b;
    b = mk(0, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 8191), 0);
    if (legal_only != 0 || $urandom_range(0, 9) < 8) b.cls = 3'($urandom_range(0, 4));
    else                                             b.cls = 3'($urandom_range(5, 7));
    return b;
  endfunction

  // Presents a bundle (at posedge+1) and holds it until accepted; returns at posedge+1.
  task automatic send(input bundle_t b);
    int   n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; in_class = b.cls; in_funct3 = b.f3; in_funct7 = b.f7; in_rd = b.rd;
    in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm; in_last = b.last;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 20);
    #1 in_valid = 1'b0;
    checks++;
    if (!rdy) begin errors++; $display("FAIL accept_timeout in_ready got 0 want 1"); end
  endtask

  task automatic do_start;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_class = '0; in_funct3 = '0;
    in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, imem_we, busy, done, err_illegal, err_align, err_overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {in_ready, imem_we, busy, done, err_illegal, err_align, err_overflow});
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== '0) begin
      errors++; $display("FAIL reset_bus got addr %0d data %h want 0 0", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_rtype;
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL load_entry got busy %b ready %b want 1 1", busy, in_ready);
    end
    send(mk(0, 0, 0, 3, 1, 2, 0, 1));
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== '0 || imem_wdata !== 32'h002081B3) begin
      errors++;
      $display("FAIL rtype_write got we %b addr %0d data %h want 1 0 002081b3",
               imem_we, imem_addr, imem_wdata);
    end
    settle(1);
    checks++;
    if (done !== 1'b1 || count !== 1) begin
      errors++; $display("FAIL rtype_done got done %b count %0d want 1 1", done, count);
    end
    settle(1);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 1) begin
      errors++;
      $display("FAIL rtype_idle got done %b busy %b count %0d want 0 0 1", done, busy, count);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = wr_q.size();
    do_start();
    send(mk(1, 0, 0, 5, 0, 0, 13'h1FFF, 0));
    send(mk(2, 2, 0, 6, 2, 0, 8, 1));
    settle(3);
    checks++;
    if (wr_q.size() - base !== 2) begin
      errors++; $display("FAIL b2b_nwrites got %0d want 2", wr_q.size() - base);
    end else begin
      checks++;
      if (wr_q[base].addr !== 0 || wr_q[base].data !== 32'hFFF00293) begin
        errors++; $display("FAIL b2b_addi got %0d %h want 0 fff00293",
                           wr_q[base].addr, wr_q[base].data);
      end
      checks++;
      if (wr_q[base+1].addr !== 1 || wr_q[base+1].data !== 32'h00812303) begin
        errors++; $display("FAIL b2b_lw got %0d %h want 1 00812303",
                           wr_q[base+1].addr, wr_q[base+1].data);
      end
      checks++;
      if (wr_q[base+1].cyc - wr_q[base].cyc !== 1) begin
        errors++; $display("FAIL b2b_gap got %0d want 1", wr_q[base+1].cyc - wr_q[base].cyc);
      end
    end
  endtask

  task automatic test_store_branch;
    int base;
    base = wr_q.size();
    do_start();
    send(mk(3, 2, 0, 0, 2, 6, 12, 0));
    send(mk(4, 0, 0, 0, 1, 2, 13'h1FFC, 0));
    checks++;
    if (err_align !== 1'b0) begin errors++; $display("FAIL align_early got 1 want 0"); end
    send(mk(4, 1, 0, 0, 3, 4, 5, 1));
    settle(3);
    checks++;
    if (wr_q.size() - base !== 3) begin
      errors++; $display("FAIL sb_nwrites got %0d want 3", wr_q.size() - base);
    end else begin
      checks++;
      if (wr_q[base].data !== 32'h00612623) begin
        errors++; $display("FAIL sb_sw got %h want 00612623", wr_q[base].data);
      end
      checks++;
      if (wr_q[base+1].data !== 32'hFE208EE3) begin
        errors++; $display("FAIL sb_beq got %h want fe208ee3", wr_q[base+1].data);
      end
      checks++;
      if (wr_q[base+2].addr !== 2 || wr_q[base+2].data !== ref_enc(mk(4, 1, 0, 0, 3, 4, 5, 1))) begin
        errors++; $display("FAIL sb_misaligned got %0d %h want 2 %h", wr_q[base+2].addr,
                           wr_q[base+2].data, ref_enc(mk(4, 1, 0, 0, 3, 4, 5, 1)));
      end
    end
    checks++;
    if (err_align !== 1'b1 || count !== 3) begin
      errors++; $display("FAIL sb_flags got align %b count %0d want 1 3", err_align, count);
    end
  endtask

  task automatic test_illegal;
    int base;
    bundle_t a, c;
    base = wr_q.size();
    a = mk(1, 0, 0, 7, 8, 0, 100, 0);
    c = mk(0, 5, 32, 9, 10, 11, 0, 1);
    do_start();
    send(a);
    send(mk(6, 0, 0, 1, 1, 1, 1, 0));
    send(c);
    settle(3);
    checks++;
    if (err_illegal !== 1'b1 || count !== 2 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_flags got ill %b count %0d busy %b want 1 2 0",
                         err_illegal, count, busy);
    end
    checks++;
    if (wr_q.size() - base !== 2) begin
      errors++; $display("FAIL illegal_nwrites got %0d want 2", wr_q.size() - base);
    end else begin
      checks++;
      if (wr_q[base].addr !== 0 || wr_q[base+1].addr !== 1 ||
          wr_q[base].data !== ref_enc(a) || wr_q[base+1].data !== ref_enc(c)) begin
        errors++; $display("FAIL illegal_words got %0d:%h %0d:%h want 0:%h 1:%h",
                           wr_q[base].addr, wr_q[base].data, wr_q[base+1].addr,
                           wr_q[base+1].data, ref_enc(a), ref_enc(c));
      end
    end
  endtask

  task automatic test_overflow;
    int base, d0, seen;
    base = wr_q.size();
    d0 = done_cnt;
    seen = 0;
    do_start();
    for (int i = 0; i < DEPTH; i++) send(rand_bundle(1));
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got 1 want 0"); end
    in_valid = 1'b1; in_class = 3'd0; in_last = 1'b0;
    repeat (4) begin @(negedge clk); if (in_ready) seen++; end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL ovf_fifth got %0d ready cycles want 0", seen); end
    checks++;
    if (err_overflow !== 1'b1 || count !== DEPTH || busy !== 1'b1 || done_cnt !== d0) begin
      errors++; $display("FAIL ovf_flags got ovf %b count %0d busy %b done %0d want 1 4 1 0",
                         err_overflow, count, busy, done_cnt - d0);
    end
    checks++;
    if (wr_q.size() - base !== DEPTH) begin
      errors++; $display("FAIL ovf_nwrites got %0d want 4", wr_q.size() - base);
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        checks++;
        if (wr_q[base+j].addr !== AW'(j)) begin
          errors++; $display("FAIL ovf_addr[%0d] got %0d want %0d", j, wr_q[base+j].addr, j);
        end
      end
    end
    do_reset();
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      bundle_t b;
      b = rand_bundle(1);
      b.last = (i == DEPTH - 1);
      send(b);
    end
    settle(3);
    checks++;
    if (err_overflow !== 1'b0 || done_cnt - d0 !== 1 || count !== DEPTH || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_last got ovf %b done %0d count %0d busy %b want 0 1 4 0",
                         err_overflow, done_cnt - d0, count, busy);
    end
  endtask

  task automatic test_reset_mid;
    do_start();
    send(mk(1, 0, 0, 1, 1, 0, 1, 0));
    do_reset();
    checks++;
    if ({imem_we, in_ready, busy, done, err_illegal, err_align, err_overflow} !== 7'b0 ||
        count !== '0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++; $display("FAIL midreset got we %b busy %b count %0d addr %0d data %h want all 0",
                         imem_we, busy, count, imem_addr, imem_wdata);
    end
    do_start();
    send(mk(0, 0, 0, 3, 1, 2, 0, 1));
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== '0) begin
      errors++; $display("FAIL midreset_restart got we %b addr %0d want 1 0", imem_we, imem_addr);
    end
    settle(3);
  endtask

  task automatic test_random;
    bundle_t     b;
    int          len, base, d0;
    logic        e_ill, e_al, e_ov;
    logic [31:0] exp_w[$];
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 6);
      base = wr_q.size();
      d0 = done_cnt;
      exp_w = {};
      e_ill = 1'b0; e_al = 1'b0; e_ov = 1'b0;
      do_start();
      for (int i = 0; i < len; i++) begin
        b = rand_bundle(0);
        b.last = (i == len - 1);
        send(b);
        if (b.cls > 3'd4) e_ill = 1'b1;
        else begin
          exp_w.push_back(ref_enc(b));
          if (b.cls == 3'd4 && b.imm[0]) e_al = 1'b1;
        end
        if (b.last) break;
        if (exp_w.size() == DEPTH) begin e_ov = 1'b1; break; end
        settle($urandom_range(0, 2));
      end
      settle(3);
      checks++;
      if ({err_illegal, err_align, err_overflow, busy} !== {e_ill, e_al, e_ov, e_ov}) begin
        errors++; $display("FAIL rnd%0d_flags got %b want %b", s,
                           {err_illegal, err_align, err_overflow, busy}, {e_ill, e_al, e_ov, e_ov});
      end
      checks++;
      if (count !== exp_w.size() || done_cnt - d0 !== (e_ov ? 0 : 1)) begin
        errors++; $display("FAIL rnd%0d_count got %0d done %0d want %0d %0d", s, count,
                           done_cnt - d0, exp_w.size(), e_ov ? 0 : 1);
      end
      checks++;
      if (wr_q.size() - base !== exp_w.size()) begin
        errors++; $display("FAIL rnd%0d_nwrites got %0d want %0d", s, wr_q.size() - base,
                           exp_w.size());
      end else begin
        for (int j = 0; j < exp_w.size(); j++) begin
          checks++;
          if (wr_q[base+j].addr !== AW'(j) || wr_q[base+j].data !== exp_w[j]) begin
            errors++; $display("FAIL rnd%0d_word%0d got %0d:%h want %0d:%h", s, j,
                               wr_q[base+j].addr, wr_q[base+j].data, j, exp_w[j]);
          end
        end
      end
      if (e_ov) do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_store_branch();
    test_illegal();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
